// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets inside the
// 32-byte window, STATUS bit positions and the state encoding that both the
// transmit and receive state machines use.
package uart_pkg;

   localparam logic [4:0] OFS_DATA   = 5'h00;
   localparam logic [4:0] OFS_STATUS = 5'h10;

   localparam int STAT_TX_READY  = 0;
   localparam int STAT_RX_VALID  = 1;
   localparam int STAT_FRAME_ERR = 2;
   localparam int STAT_OVERRUN   = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uartState_e;

endpackage

// File: rtl/uart_rx_core.sv
// Receive path: two-flop synchroniser on the raw line, falling-edge start
// detection, mid-bit sampling of eight data bits LSB first and a stop-bit
// check. Delivers a one-cycle done pulse with the byte, or a one-cycle
// framing-error pulse when the stop bit is low.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLK_DIV = 434
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       rx_i,
   output logic [7:0] rxByte_o,
   output logic       rxDone_o,
   output logic       frameErr_o
);

   localparam logic [15:0] BIT_LAST  = 16'(CLK_DIV - 1);
   localparam logic [15:0] HALF_LAST = 16'((CLK_DIV / 2) - 1);

   logic       sync1_q;
   logic       sync2_q;
   logic       rxLast_q;
   uartState_e state_q;
   logic [15:0] cnt_q;
   logic [2:0] bitIdx_q;
   logic [7:0] shift_q;
   logic       errWait_q;
   logic [7:0] rxByte_q;
   logic       rxDone_q;
   logic       frameErr_q;

   assign rxByte_o   = rxByte_q;
   assign rxDone_o   = rxDone_q;
   assign frameErr_o = frameErr_q;

   // Bring the asynchronous line into the clock domain and keep one extra
   // delayed copy so a high-to-low transition can be recognised.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         rxLast_q <= 1'b1;
      end else begin
         sync1_q  <= rx_i;
         sync2_q  <= sync1_q;
         rxLast_q <= sync2_q;
      end
   end

   // Receive state machine; after a low stop bit it lingers in STOP until the
   // line has returned high so the tail of a broken frame cannot retrigger.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bitIdx_q   <= '0;
         shift_q    <= '0;
         errWait_q  <= 1'b0;
         rxByte_q   <= '0;
         rxDone_q   <= 1'b0;
         frameErr_q <= 1'b0;
      end else begin
         rxDone_q   <= 1'b0;
         frameErr_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               if (rxLast_q && !sync2_q) begin
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (cnt_q == HALF_LAST) begin
                  cnt_q <= '0;
                  if (sync2_q) begin
                     state_q <= ST_IDLE;
                  end else begin
                     bitIdx_q <= '0;
                     state_q  <= ST_DATA;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            ST_DATA: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q   <= '0;
                  shift_q <= {sync2_q, shift_q[7:1]};
                  if (bitIdx_q == 3'd7) begin
                     state_q <= ST_STOP;
                  end else begin
                     bitIdx_q <= bitIdx_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            ST_STOP: begin
               if (errWait_q) begin
                  if (sync2_q) begin
                     errWait_q <= 1'b0;
                     state_q   <= ST_IDLE;
                  end
               end else if (cnt_q == BIT_LAST) begin
                  cnt_q <= '0;
                  if (sync2_q) begin
                     rxByte_q <= shift_q;
                     rxDone_q <= 1'b1;
                     state_q  <= ST_IDLE;
                  end else begin
                     frameErr_q <= 1'b1;
                     errWait_q  <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART: bus decode of the DATA/STATUS window, the transmit
// state machine and the receive flags. The receive path itself lives in
// uart_rx_core.
module uart_mmio
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h7000_0000,
   parameter int          CLK_DIV   = 434
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        mem_valid,
   input  logic        mem_write,
   input  logic [3:0]  mem_wmask,
   input  logic [31:0] mem_wdata,
   input  logic [31:0] mem_addr,
   output logic [31:0] mem_rdata,
   output logic        uart_tx,
   input  logic        uart_rx
);

   localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);

   logic       sel;
   logic [4:0] offset;
   logic       dataWrite;
   logic       statusWrite;
   logic       dataRead;
   logic       statusRead;
   logic       txReady;

   uartState_e  txState_q;
   logic [15:0] txCnt_q;
   logic [2:0]  txBit_q;
   logic [7:0]  txShift_q;
   logic        txLine_q;

   logic [7:0]  rxByte;
   logic        rxDone;
   logic        frameErrPulse;

   logic [7:0]  rxData_q,   rxData_d;
   logic        rxValid_q,  rxValid_d;
   logic        frameErr_q, frameErr_d;
   logic        overrun_q,  overrun_d;
   logic [31:0] rdata_q,    rdata_d;

   logic        unusedBits;

   assign sel         = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
   assign offset      = mem_addr[4:0];
   assign dataWrite   = sel && mem_write && (offset == OFS_DATA) && mem_wmask[0];
   assign statusWrite = sel && mem_write && (offset == OFS_STATUS) && mem_wmask[0];
   assign dataRead    = sel && !mem_write && (offset == OFS_DATA);
   assign statusRead  = sel && !mem_write && (offset == OFS_STATUS);
   assign txReady     = (txState_q == ST_IDLE);
   assign uart_tx     = txLine_q;
   assign mem_rdata   = rdata_q;
   assign unusedBits  = ^{mem_wdata[31:8], mem_wmask[3:1]};

   uart_rx_core #(
      .CLK_DIV (CLK_DIV)
   ) u_rx (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .rx_i       (uart_rx),
      .rxByte_o   (rxByte),
      .rxDone_o   (rxDone),
      .frameErr_o (frameErrPulse)
   );

   // Transmit state machine; a DATA write is only taken in IDLE, so writes
   // while a frame is on the wire are silently dropped.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         txState_q <= ST_IDLE;
         txCnt_q   <= '0;
         txBit_q   <= '0;
         txShift_q <= '0;
         txLine_q  <= 1'b1;
      end else begin
         case (txState_q)
            ST_IDLE: begin
               txLine_q <= 1'b1;
               txCnt_q  <= '0;
               if (dataWrite) begin
                  txShift_q <= mem_wdata[7:0];
                  txLine_q  <= 1'b0;
                  txState_q <= ST_START;
               end
            end
            ST_START: begin
               if (txCnt_q == BIT_LAST) begin
                  txCnt_q   <= '0;
                  txBit_q   <= '0;
                  txLine_q  <= txShift_q[0];
                  txShift_q <= {1'b0, txShift_q[7:1]};
                  txState_q <= ST_DATA;
               end else begin
                  txCnt_q <= txCnt_q + 16'd1;
               end
            end
            ST_DATA: begin
               if (txCnt_q == BIT_LAST) begin
                  txCnt_q <= '0;
                  if (txBit_q == 3'd7) begin
                     txLine_q  <= 1'b1;
                     txState_q <= ST_STOP;
                  end else begin
                     txBit_q   <= txBit_q + 3'd1;
                     txLine_q  <= txShift_q[0];
                     txShift_q <= {1'b0, txShift_q[7:1]};
                  end
               end else begin
                  txCnt_q <= txCnt_q + 16'd1;
               end
            end
            ST_STOP: begin
               if (txCnt_q == BIT_LAST) begin
                  txCnt_q   <= '0;
                  txState_q <= ST_IDLE;
               end else begin
                  txCnt_q <= txCnt_q + 16'd1;
               end
            end
            default: txState_q <= ST_IDLE;
         endcase
      end
   end

   // Next values of the receive flags and read data; a new byte or error
   // always wins over a clear arriving in the same cycle.
   always_comb begin
      rxData_d   = rxDone ? rxByte : rxData_q;
      rxValid_d  = rxDone | (rxValid_q & ~dataRead);
      overrun_d  = (rxDone & rxValid_q & ~dataRead)
                 | (overrun_q & ~(statusWrite & mem_wdata[STAT_OVERRUN]));
      frameErr_d = frameErrPulse
                 | (frameErr_q & ~(statusWrite & mem_wdata[STAT_FRAME_ERR]));
      rdata_d    = '0;
      if (dataRead) begin
         rdata_d = {24'b0, rxData_q};
      end else if (statusRead) begin
         rdata_d[STAT_TX_READY]  = txReady;
         rdata_d[STAT_RX_VALID]  = rxValid_q;
         rdata_d[STAT_FRAME_ERR] = frameErr_q;
         rdata_d[STAT_OVERRUN]   = overrun_q;
      end
   end

   // Register the receive flags and the bus read data.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rxData_q   <= '0;
         rxValid_q  <= 1'b0;
         frameErr_q <= 1'b0;
         overrun_q  <= 1'b0;
         rdata_q    <= '0;
      end else begin
         rxData_q   <= rxData_d;
         rxValid_q  <= rxValid_d;
         frameErr_q <= frameErr_d;
         overrun_q  <= overrun_d;
         rdata_q    <= rdata_d;
      end
   end

endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio with CLK_DIV=8. A behavioural model tracks the expected
// transmit waveform as a function of the cycle a write was accepted, and the
// receive flags as a function of complete frames and bus accesses.
module tb_uart_mmio;

   localparam int          D    = 8;
   localparam logic [31:0] BASE = 32'h7000_0000;
   localparam logic [31:0] STAT = BASE + 32'h10;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        mem_valid = 1'b0;
   logic        mem_write = 1'b0;
   logic [3:0]  mem_wmask = 4'h0;
   logic [31:0] mem_wdata = '0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_rdata;
   logic        uart_tx;
   logic        uart_rx = 1'b1;

   int testsRun = 0;
   int failCount = 0;
   int edgeCnt = 0;
   bit monitorOn = 1'b0;

   bit         txActive = 1'b0;
   int         acceptEdge = 0;
   logic [7:0] txByte = '0;
   bit         mRxValid = 1'b0;
   bit         mFrameErr = 1'b0;
   bit         mOverrun = 1'b0;
   logic [7:0] mRxData = '0;

   uart_mmio #(
      .BASE_ADDR (BASE),
      .CLK_DIV   (D)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .mem_valid (mem_valid),
      .mem_write (mem_write),
      .mem_wmask (mem_wmask),
      .mem_wdata (mem_wdata),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .uart_tx   (uart_tx),
      .uart_rx   (uart_rx)
   );

   // Free-running clock and a count of its rising edges.
   always #5 clk = ~clk;
   always @(posedge clk) edgeCnt++;

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", tag, actual, expected, edgeCnt);
      end
   endtask

   // A frame occupies the 10*D cycles that follow the accepting edge.
   function automatic bit txBusy(input int e);
      int k;
      k = e - acceptEdge;
      return txActive && (k >= 0) && (k < 10 * D);
   endfunction

   // Line level after edge e: start bit, eight data bits LSB first, stop bit.
   function automatic logic expTx(input int e);
      int idx;
      if (!txBusy(e)) return 1'b1;
      idx = (e - acceptEdge) / D;
      if (idx == 0) return 1'b0;
      if (idx == 9) return 1'b1;
      return txByte[idx-1];
   endfunction

   function automatic logic [31:0] expStatus(input int e);
      return {28'b0, mOverrun, mFrameErr, mRxValid, !txBusy(e)};
   endfunction

   function automatic bit isSel(input logic [31:0] a);
      return a[31:5] == BASE[31:5];
   endfunction

   // Transmit line compared against the model on every falling edge.
   always @(negedge clk) begin
      if (monitorOn) checkOutput("uart_tx", {31'b0, uart_tx}, {31'b0, expTx(edgeCnt)});
   end

   task automatic applyReset();
      rstn = 1'b0;
      uart_rx = 1'b1;
      mem_valid = 1'b0;
      mem_write = 1'b0;
      @(posedge clk);
      txActive = 1'b0;
      mRxValid = 1'b0;
      mFrameErr = 1'b0;
      mOverrun = 1'b0;
      mRxData = '0;
      @(negedge clk);
      rstn = 1'b1;
      checkOutput("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
      checkOutput("rst_rdata", mem_rdata, 32'h0);
   endtask

   task automatic busWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
      int e;
      e = edgeCnt;
      if (isSel(addr) && addr[4:0] == 5'h00 && mask[0] && !txBusy(e)) begin
         txActive = 1'b1;
         acceptEdge = e + 1;
         txByte = data[7:0];
      end
      if (isSel(addr) && addr[4:0] == 5'h10 && mask[0]) begin
         if (data[2]) mFrameErr = 1'b0;
         if (data[3]) mOverrun = 1'b0;
      end
      mem_addr = addr;
      mem_wdata = data;
      mem_wmask = mask;
      mem_write = 1'b1;
      mem_valid = 1'b1;
      @(negedge clk);
      mem_valid = 1'b0;
      mem_write = 1'b0;
      checkOutput("wr_rdata", mem_rdata, 32'h0);
   endtask

   task automatic busRead(input logic [31:0] addr, input string tag);
      logic [31:0] exp;
      exp = '0;
      if (isSel(addr) && addr[4:0] == 5'h00) exp = {24'b0, mRxData};
      else if (isSel(addr) && addr[4:0] == 5'h10) exp = expStatus(edgeCnt);
      mem_addr = addr;
      mem_write = 1'b0;
      mem_valid = 1'b1;
      @(negedge clk);
      mem_valid = 1'b0;
      checkOutput(tag, mem_rdata, exp);
      if (isSel(addr) && addr[4:0] == 5'h00) mRxValid = 1'b0;
   endtask

   task automatic sendFrame(input logic [7:0] b, input logic stopBit);
      for (int i = 0; i < 10; i++) begin
         uart_rx = (i == 0) ? 1'b0 : (i == 9) ? stopBit : b[i-1];
         repeat (D) @(negedge clk);
      end
      uart_rx = 1'b1;
      if (stopBit) begin
         mOverrun = mOverrun | mRxValid;
         mRxValid = 1'b1;
         mRxData = b;
      end else begin
         mFrameErr = 1'b1;
      end
      repeat (4) @(negedge clk);
   endtask

   // One randomized round: a receive frame, optionally overlapped by a
   // transmit write, followed by a random bus operation and status checks.
   task automatic applyStimulus();
      logic [7:0]  b;
      logic        stopBit;
      bit          doTx;
      int          dly;
      logic [31:0] wd;
      logic [3:0]  wm;
      int          op;
      logic [4:0]  off;
      b = 8'($urandom);
      stopBit = ($urandom_range(0, 5) != 0);
      doTx = 1'($urandom_range(0, 1));
      dly = $urandom_range(1, 70);
      wd = $urandom;
      wm = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 2) != 0);
      fork
         sendFrame(b, stopBit);
         begin
            if (doTx) begin
               repeat (dly) @(negedge clk);
               busWrite(BASE, wd, wm);
            end
         end
      join
      op = $urandom_range(0, 5);
      case (op)
         0: busRead(BASE, "rnd_data_op");
         1: busRead(STAT, "rnd_status_op");
         2: busWrite(STAT, $urandom, 4'($urandom_range(0, 15)));
         3: begin
            off = 5'($urandom_range(1, 31));
            if (off == 5'h10) off = 5'h08;
            busRead(BASE + {27'b0, off}, "rnd_unmapped");
         end
         4: busWrite(BASE, $urandom, 4'($urandom_range(0, 15)));
         default: busRead(BASE + 32'h20 + 32'($urandom_range(0, 31)), "rnd_unselected");
      endcase
      busRead(STAT, "rnd_status");
      if ($urandom_range(0, 1) == 1) busRead(BASE, "rnd_data");
   endtask

   initial begin
      repeat (3) @(negedge clk);
      applyReset();
      monitorOn = 1'b1;
      busRead(STAT, "reset_status");
      busRead(BASE, "reset_data");

      // 0x55 frame, with tx_ready checked on both sides of the 10*D boundary.
      busWrite(BASE, 32'h55, 4'hF);
      while (edgeCnt < acceptEdge + 10 * D - 1) @(negedge clk);
      busRead(STAT, "tx_ready_last_busy");
      busRead(STAT, "tx_ready_back");

      // Second write during a frame is dropped.
      busWrite(BASE, 32'hA5, 4'h1);
      repeat (18) @(negedge clk);
      busWrite(BASE, 32'h3C, 4'hF);
      busRead(STAT, "status_while_busy");
      repeat (70) @(negedge clk);

      // DATA write without byte lane 0 is ignored.
      busWrite(BASE, 32'h33, 4'hE);
      repeat (5) @(negedge clk);
      busRead(STAT, "status_mask0");
      busRead(BASE + 32'h04, "unmapped_read");
      busRead(BASE + 32'h30, "unselected_read");

      // Receive 0xC3 while a transmit is in flight.
      fork
         sendFrame(8'hC3, 1'b1);
         begin
            repeat (30) @(negedge clk);
            busWrite(BASE, 32'h5A, 4'hF);
         end
      join
      busRead(STAT, "rx_status_valid");
      busRead(BASE, "rx_data_c3");
      busRead(STAT, "rx_status_cleared");

      // Two frames without reading: overrun, then write-1-to-clear.
      fork
         begin
            sendFrame(8'h11, 1'b1);
            sendFrame(8'h22, 1'b1);
         end
         begin
            repeat (120) @(negedge clk);
            busWrite(BASE, 32'h77, 4'hF);
         end
      join
      busRead(STAT, "ovr_status");
      busRead(BASE, "ovr_data_22");
      busWrite(STAT, 32'h8, 4'h1);
      busRead(STAT, "ovr_cleared");

      // Framing error, then a short glitch that must be rejected.
      sendFrame(8'h5A, 1'b0);
      busRead(STAT, "frame_err_status");
      uart_rx = 1'b0;
      repeat (3) @(negedge clk);
      uart_rx = 1'b1;
      repeat (20) @(negedge clk);
      busRead(STAT, "glitch_status");
      busRead(BASE, "glitch_data");
      busWrite(STAT, 32'h4, 4'h1);
      busRead(STAT, "frame_err_cleared");

      // Reset in the middle of both a transmit and a receive frame.
      busWrite(BASE, 32'h96, 4'hF);
      uart_rx = 1'b0;
      repeat (30) @(negedge clk);
      applyReset();
      busRead(STAT, "midreset_status");
      busRead(BASE, "midreset_data");
      repeat (90) @(negedge clk);
      busRead(STAT, "midreset_late_status");

      for (int i = 0; i < 25; i++) applyStimulus();
      repeat (90) @(negedge clk);

      monitorOn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
